// File: rtl/fir_seq_pkg.sv
// Shared types and width helpers for the time-multiplexed symmetric FIR.
package fir_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_e;

    function automatic int m_of(input int n);
        return (n - 1) / 2;
    endfunction

    function automatic int pre_w(input int dw);
        return dw + 1;
    endfunction

    function automatic int prod_w(input int dw, input int cw);
        return dw + cw + 1;
    endfunction

endpackage

// File: rtl/fir_sample_ring.sv
// N-deep circular sample store with one write port and two async read ports.
module fir_sample_ring #(
    parameter int N  = 51,
    parameter int DW = 16,
    localparam int IW = $clog2(N)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          we_i,
    input  logic [DW-1:0] wdata_i,
    output logic [IW-1:0] wp_o,
    input  logic [IW-1:0] rd_a_idx_i,
    input  logic [IW-1:0] rd_b_idx_i,
    output logic [DW-1:0] rd_a_o,
    output logic [DW-1:0] rd_b_o
);

    logic [DW-1:0] ring_q [N];
    logic [IW-1:0] wp_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < N; i++) begin
                ring_q[i] <= '0;
            end
            wp_q <= '0;
        end else if (we_i) begin
            ring_q[wp_q] <= wdata_i;
            wp_q <= (wp_q == IW'(N - 1)) ? '0 : wp_q + IW'(1);
        end
    end

    assign wp_o   = wp_q;
    assign rd_a_o = ring_q[rd_a_idx_i];
    assign rd_b_o = ring_q[rd_b_idx_i];

endmodule

// File: rtl/fir_sym_mac_sequencer.sv
// Symmetric FIR sequencer: one pre-adder, one multiplier, one accumulator,
// (N+1)/2 MAC cycles per sample, runtime-loadable half coefficient set.
module fir_sym_mac_sequencer
    import fir_seq_pkg::*;
#(
    parameter int N           = 51,
    parameter int DATA_WIDTH  = 16,
    parameter int COEFF_WIDTH = 16,
    parameter int ACC_WIDTH   = DATA_WIDTH + COEFF_WIDTH + 8,
    parameter int SHIFT       = 15,
    localparam int M  = m_of(N),
    localparam int AW = $clog2((N + 1) / 2),
    localparam int IW = $clog2(N)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   s_valid_i,
    output logic                   s_ready_o,
    input  logic [DATA_WIDTH-1:0]  s_data_i,
    input  logic                   coef_we_i,
    input  logic [AW-1:0]          coef_addr_i,
    input  logic [COEFF_WIDTH-1:0] coef_data_i,
    output logic                   coef_ready_o,
    output logic                   m_valid_o,
    input  logic                   m_ready_i,
    output logic [ACC_WIDTH-1:0]   m_data_o,
    output logic                   busy_o
);

    localparam int PW = pre_w(DATA_WIDTH);
    localparam int XW = prod_w(DATA_WIDTH, COEFF_WIDTH);

    state_e                 state_q, state_d;
    logic [AW-1:0]          k_q, k_d;
    logic [IW-1:0]          base_q, base_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                   m_valid_q, m_valid_d;
    logic [COEFF_WIDTH-1:0] coef_q [M+1];

    logic                   ring_we;
    logic [IW-1:0]          wp;
    logic [IW:0]            ia_w, ib_w;
    logic [DATA_WIDTH-1:0]  ra, rb;
    logic signed [PW-1:0]   pre;
    logic signed [XW-1:0]   prod;

    fir_sample_ring #(
        .N  (N),
        .DW (DATA_WIDTH)
    ) u_ring (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .we_i       (ring_we),
        .wdata_i    (s_data_i),
        .wp_o       (wp),
        .rd_a_idx_i (ia_w[IW-1:0]),
        .rd_b_idx_i (ib_w[IW-1:0]),
        .rd_a_o     (ra),
        .rd_b_o     (rb)
    );

    // Tap pair (base-k, base-(N-1-k)) mod N; the second equals base+k+1 mod N.
    always_comb begin
        ia_w = {1'b0, base_q} + (IW+1)'(N) - (IW+1)'(k_q);
        if (ia_w >= (IW+1)'(N)) begin
            ia_w = ia_w - (IW+1)'(N);
        end
        ib_w = {1'b0, base_q} + (IW+1)'(k_q) + (IW+1)'(1);
        if (ib_w >= (IW+1)'(N)) begin
            ib_w = ib_w - (IW+1)'(N);
        end
    end

    always_comb begin
        pre = {ra[DATA_WIDTH-1], ra};
        if (k_q != AW'(M)) begin
            pre = pre + $signed({rb[DATA_WIDTH-1], rb});
        end
        prod = XW'($signed(coef_q[k_q])) * XW'(pre);
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        base_d    = base_q;
        acc_d     = acc_q;
        m_valid_d = m_valid_q;
        ring_we   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (s_valid_i) begin
                    ring_we = 1'b1;
                    base_d  = wp;
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = acc_q + ACC_WIDTH'(prod);
                if (k_q == AW'(M)) begin
                    state_d   = OUT;
                    m_valid_d = 1'b1;
                end else begin
                    k_d = k_q + AW'(1);
                end
            end
            OUT: begin
                if (m_ready_i) begin
                    state_d   = IDLE;
                    m_valid_d = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                m_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            k_q       <= '0;
            base_q    <= '0;
            acc_q     <= '0;
            m_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            base_q    <= base_d;
            acc_q     <= acc_d;
            m_valid_q <= m_valid_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i <= M; i++) begin
                coef_q[i] <= '0;
            end
        end else if (coef_we_i && state_q == IDLE && coef_addr_i <= AW'(M)) begin
            coef_q[coef_addr_i] <= coef_data_i;
        end
    end

    assign s_ready_o    = (state_q == IDLE);
    assign coef_ready_o = (state_q == IDLE);
    assign busy_o       = (state_q != IDLE);
    assign m_valid_o    = m_valid_q;
    assign m_data_o     = acc_q >>> SHIFT;

endmodule
